// File: rtl/fb_page_streamer.sv
// fb_page_streamer: reads a framebuffer one column byte at a time, page-major,
// and hands each page byte to a display serializer over a valid/ready handshake.
module fb_page_streamer #(
    parameter int H_PIXELS    = 128,
    parameter int V_PIXELS    = 64,
    parameter bit BIT_REVERSE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       fb_ready,
    output logic       fb_re,
    output logic [7:0] fb_r_xpos,
    output logic [7:0] fb_r_ypos,
    output logic       fb_r_mode,
    input  logic       fb_r_data_valid,
    input  logic [7:0] fb_dout,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    input  logic       byte_ready,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [7:0] COL_LAST  = 8'(H_PIXELS - 1);
    localparam logic [2:0] PAGE_LAST = 3'(V_PIXELS / 8 - 1);

    typedef enum logic [1:0] {IDLE, REQ, OUT, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] col_q, col_d;
    logic [2:0] page_q, page_d;
    logic       re_q, re_d;
    logic       bv_q, bv_d;
    logic [7:0] bd_q, bd_d;
    logic [7:0] din_rev;
    logic       col_last;

    // Panel pages want bit0 = top row; the framebuffer delivers the top row in bit7.
    for (genvar i = 0; i < 8; i++) begin : g_rev
        assign din_rev[i] = fb_dout[7-i];
    end

    assign col_last = col_q == COL_LAST;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        page_d  = page_q;
        re_d    = re_q;
        bv_d    = bv_q;
        bd_d    = bd_q;
        case (state_q)
            IDLE: if (start && fb_ready) begin
                col_d   = '0;
                page_d  = '0;
                re_d    = 1'b1;
                state_d = REQ;
            end
            REQ: if (abort) begin
                re_d    = 1'b0;
                bv_d    = 1'b0;
                state_d = IDLE;
            end else if (fb_r_data_valid) begin
                bd_d    = BIT_REVERSE ? din_rev : fb_dout;
                bv_d    = 1'b1;
                re_d    = 1'b0;
                state_d = OUT;
            end
            OUT: if (abort) begin
                re_d    = 1'b0;
                bv_d    = 1'b0;
                state_d = IDLE;
            end else if (byte_ready) begin
                bv_d    = 1'b0;
                col_d   = col_last ? 8'd0 : col_q + 8'd1;
                page_d  = col_last ? page_q + 3'd1 : page_q;
                if (col_last && page_q == PAGE_LAST) begin
                    state_d = DONE;
                end else begin
                    re_d    = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            page_q  <= '0;
            re_q    <= 1'b0;
            bv_q    <= 1'b0;
            bd_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            page_q  <= page_d;
            re_q    <= re_d;
            bv_q    <= bv_d;
            bd_q    <= bd_d;
        end
    end

    assign fb_re      = re_q;
    assign fb_r_xpos  = col_q;
    assign fb_r_ypos  = {2'b00, page_q, 3'b000};
    assign fb_r_mode  = 1'b1;
    assign byte_valid = bv_q;
    assign byte_data  = bd_q;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_fb_page_streamer.sv
// tb_fb_page_streamer: randomized framebuffer/back-pressure bench with a
// page-major byte scoreboard checked by an independent monitor.
module tb_fb_page_streamer;
    localparam int H  = 128;
    localparam int V  = 64;
    localparam int NB = H * V / 8;
    localparam bit BR = 1;

    logic       clk = 0, rst = 1, start = 0, abort = 0, fb_ready = 0;
    logic       fb_r_data_valid = 0, byte_ready = 0;
    logic [7:0] fb_dout = 0;
    logic       fb_re, fb_r_mode, byte_valid, busy, frame_done;
    logic [7:0] fb_r_xpos, fb_r_ypos, byte_data;

    fb_page_streamer #(.H_PIXELS(H), .V_PIXELS(V), .BIT_REVERSE(BR)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fb_ready(fb_ready),
        .fb_re(fb_re), .fb_r_xpos(fb_r_xpos), .fb_r_ypos(fb_r_ypos), .fb_r_mode(fb_r_mode),
        .fb_r_data_valid(fb_r_data_valid), .fb_dout(fb_dout),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0, done_cnt = 0, acc_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[0:8191];
    bit         bp = 0;

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask

    function automatic logic [7:0] pat(int x, int y);
        if (x == 5 && y == 8) return 8'h80;
        return 8'((x * 37) ^ (y * 11) ^ 90);
    endfunction

    function automatic logic [7:0] rev8(logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    task automatic push_frame();
        for (int p = 0; p < V / 8; p++)
            for (int c = 0; c < H; c++)
                exp_q.push_back(BR ? rev8(pat(c, p * 8)) : pat(c, p * 8));
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Framebuffer with random read latency, plus random downstream back-pressure.
    initial forever begin
        @(posedge clk);
        #1;
        fb_r_data_valid = fb_re && ($urandom_range(0, 1) == 0);
        fb_dout         = fb_r_data_valid ? pat(int'(fb_r_xpos), int'(fb_r_ypos)) : 8'($urandom);
        byte_ready      = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    logic       pv = 0, prdy = 0, pab = 1, pre = 0, pval = 0, pfd = 0, seen_low = 1;
    logic [7:0] pd = 0, px = 0, py = 0;

    initial forever begin
        logic       ab;
        logic [7:0] e;
        @(negedge clk);
        ab = abort || rst;
        if (byte_valid && byte_ready && !ab) begin
            got[acc_total] = byte_data;
            acc_total++;
            chk("queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("byte", byte_data, e);
            end
        end
        if (pv && !prdy && !pab) begin
            chk("hold_valid", byte_valid, 1);
            chk("hold_data", byte_data, pd);
        end
        if (pre && !pval && !pab) begin
            chk("hold_re", fb_re, 1);
            chk("hold_xpos", fb_r_xpos, px);
            chk("hold_ypos", fb_r_ypos, py);
        end
        if (fb_re && fb_r_data_valid && !ab) begin
            chk("re_gap", seen_low, 1);
            chk("mode", fb_r_mode, 1);
            seen_low = 0;
        end else if (!fb_re) seen_low = 1;
        if (frame_done) begin
            done_cnt++;
            chk("done_flush", exp_q.size(), 0);
        end
        if (pfd) chk("done_pulse", frame_done, 0);
        pv = byte_valid; prdy = byte_ready; pab = ab; pd = byte_data;
        pre = fb_re; pval = fb_r_data_valid; px = fb_r_xpos; py = fb_r_ypos; pfd = frame_done;
    end

    task automatic pulse_start();
        start = 1;
        cyc(1);
        start = 0;
    endtask

    task automatic run_frame(string n);
        int d0, base, k;
        d0   = done_cnt;
        base = acc_total;
        k    = 0;
        push_frame();
        pulse_start();
        while (done_cnt == d0 && k < 20000) begin
            cyc(1);
            k++;
        end
        cyc(3);
        chk({n, "_done_count"}, done_cnt - d0, 1);
        chk({n, "_bytes"}, acc_total - base, NB);
        chk({n, "_idle"}, busy, 0);
    endtask

    initial begin
        int base, d0, k;
        rst = 1;
        cyc(3);
        chk("rst_re", fb_re, 0);
        chk("rst_bv", byte_valid, 0);
        chk("rst_bd", byte_data, 0);
        chk("rst_x", fb_r_xpos, 0);
        chk("rst_y", fb_r_ypos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_mode", fb_r_mode, 1);
        rst = 0;
        cyc(2);
        chk("idle_after_rst", busy, 0);

        fb_ready = 0;
        pulse_start();
        k = 0;
        repeat (5) begin
            if (fb_re || busy) k++;
            cyc(1);
        end
        chk("start_dropped", k, 0);
        fb_ready = 1;

        bp   = 0;
        base = acc_total;
        run_frame("frame1");
        chk("byte133", got[base+133], BR ? 8'h01 : 8'h80);

        bp   = 1;
        d0   = done_cnt;
        base = acc_total;
        k    = 0;
        push_frame();
        pulse_start();
        cyc(50);
        pulse_start();
        chk("busy_on_restart", busy, 1);
        while (done_cnt == d0 && k < 20000) begin
            cyc(1);
            k++;
        end
        cyc(3);
        chk("frame2_done_count", done_cnt - d0, 1);
        chk("frame2_bytes", acc_total - base, NB);

        base = acc_total;
        k    = 0;
        push_frame();
        pulse_start();
        while (!(acc_total - base >= 300 && fb_re) && k < 20000) begin
            cyc(1);
            k++;
        end
        chk("abort_reached", acc_total - base, 300);
        d0    = done_cnt;
        abort = 1;
        cyc(1);
        abort = 0;
        chk("abort_re", fb_re, 0);
        chk("abort_bv", byte_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        cyc(5);
        chk("abort_no_done", done_cnt - d0, 0);

        base = acc_total;
        k    = 0;
        push_frame();
        pulse_start();
        while (!(acc_total - base >= 10 && byte_valid) && k < 20000) begin
            cyc(1);
            k++;
        end
        chk("rst_mid_reached", acc_total - base, 10);
        d0  = done_cnt;
        rst = 1;
        cyc(1);
        rst = 0;
        chk("rst_mid_re", fb_re, 0);
        chk("rst_mid_bv", byte_valid, 0);
        chk("rst_mid_busy", busy, 0);
        exp_q.delete();
        cyc(5);
        chk("rst_mid_no_done", done_cnt - d0, 0);

        run_frame("frame_resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
